// File: rtl/div_seq_if.sv
// div_seq_if: operand/result bundle for the sequential divider.
//
// Signals (master = pipeline side, slave = divider):
//   START  request a division (taken only while the divider is idle)
//   SIGN   1 = signed (DIV), 0 = unsigned (DIVU), taken with START
//   ABORT  synchronous cancel of an in-flight division
//   A, B   dividend / divisor, taken with START
//   BUSY   high while a division is in progress
//   DONE   one-cycle pulse, HI/LO valid from this cycle on
//   HI/LO  remainder / quotient, held until the next completed division
//
// Handshake: START acts as "valid" and !BUSY as "ready". A request is
// accepted on a rising edge where START=1, ABORT=0 and the divider is idle;
// requests seen while BUSY=1 are dropped, not queued. Completion is signalled
// by DONE alone, with no back-pressure from the consumer. The DONE cycle is
// already idle, so a new START in that cycle is accepted.
interface div_seq_if #(parameter int WIDTH = 32);
  logic             START;
  logic             SIGN;
  logic             ABORT;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output START, SIGN, ABORT, A, B,
                  input  BUSY, DONE, HI, LO);
  modport slave  (input  START, SIGN, ABORT, A, B,
                  output BUSY, DONE, HI, LO);
endinterface

// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Produces the quotient on LO and the remainder on HI. It takes WIDTH RUN
// cycles plus one FIX cycle; DONE pulses the cycle after FIX.
//
// Ports:
//   CLK        clock, rising edge
//   RESET      asynchronous, active-high reset
//   bus        div_seq_if.slave (START/SIGN/ABORT/A/B in, BUSY/DONE/HI/LO out)
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = FIX)
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  div_seq_if.slave   bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] rem, quo, b_mag, a_orig;
  logic [WIDTH-1:0] hi, lo;
  logic [CW-1:0]    count;
  logic             sign_q, a_neg, b_neg, b_zero;
  logic             busy, done;

  logic             start_ok;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  // ABORT wins over a START that arrives in the same cycle.
  assign start_ok  = bus.START && !bus.ABORT;
  assign last_iter = (count == CW'(WIDTH - 1));

  // Magnitudes are taken only for signed operands with the MSB set.
  // The most-negative value maps to itself, which is the correct unsigned
  // magnitude.
  assign a_mag_in = (bus.SIGN && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign b_mag_in = (bus.SIGN && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // {rem, quo} shifted left by one: the next dividend bit enters rem. The
  // top bit of shifted holds the carry-out. trial's MSB is its sign.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, b_mag};

  // Sign correction: the quotient is negative when the operand signs
  // differ, and the remainder follows the dividend (C truncation).
  assign q_fix = (sign_q && (a_neg ^ b_neg)) ? -quo : quo;
  assign r_fix = (sign_q && a_neg) ? -rem : rem;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = RUN;
      RUN: begin
        if (bus.ABORT)      next_state = IDLE;
        else if (last_iter) next_state = FIX;
      end
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rem    <= '0;
      quo    <= '0;
      b_mag  <= '0;
      a_orig <= '0;
      count  <= '0;
      sign_q <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      done <= (state == FIX) && !bus.ABORT;
      case (state)
        IDLE: begin
          if (start_ok) begin
            sign_q <= bus.SIGN;
            a_neg  <= bus.SIGN && bus.A[WIDTH-1];
            b_neg  <= bus.SIGN && bus.B[WIDTH-1];
            b_zero <= (bus.B == '0);
            a_orig <= bus.A;
            quo    <= a_mag_in;
            b_mag  <= b_mag_in;
            rem    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          if (!bus.ABORT) begin
            if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              // Restore: the shifted value is below b_mag, so it fits WIDTH bits.
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            count <= count + CW'(1);
          end
        end
        FIX: begin
          if (!bus.ABORT) begin
            if (b_zero) begin
              lo <= '1;
              hi <= a_orig;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.BUSY  = busy;
  assign bus.DONE  = done;
  assign bus.HI    = hi;
  assign bus.LO    = lo;
  assign dbg_state = state;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and randomized checks of div_seq against an
// arithmetic reference model (64-bit integer divide / modulo).
module tb_div_seq;
  localparam int W = 32;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad = 0;

  logic [2*W-1:0] exp_q[$];  // expected {HI, LO} per accepted start
  logic [W-1:0]   last_hi, last_lo;

  div_seq_if #(.WIDTH(W)) bus();

  div_seq #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with C truncation, divide-by-zero rule.
  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return {a, {W{1'b1}}};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // driver: one START cycle; leaves the bench in cycle 1 of the operation
  task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_q.push_back(model(s, a, b));
    bus.START = 1'b1;
    bus.SIGN  = s;
    bus.A     = a;
    bus.B     = b;
    tick;
    bus.START = 1'b0;
    bus.SIGN  = 1'($urandom);
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Waits for DONE from cycle 1; optionally pulses a stray START at inject_at.
  task automatic wait_done(input string tag, input int inject_at);
    int             cyc;
    bit             busy_ok;
    logic [2*W-1:0] e;
    cyc = 1;
    busy_ok = 1'b1;
    while (!bus.DONE && cyc < 60) begin
      if (!bus.BUSY) busy_ok = 1'b0;
      if (cyc == inject_at) begin
        bus.START = 1'b1;
        bus.SIGN  = 1'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
      end else begin
        bus.START = 1'b0;
      end
      tick;
      cyc++;
    end
    bus.START = 1'b0;
    check($sformatf("%s.latency", tag), 64'(cyc), 64'd34);
    check($sformatf("%s.busy_run", tag), 64'(busy_ok), 64'd1);
    check($sformatf("%s.busy_done", tag), 64'(bus.BUSY), 64'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check($sformatf("%s.lo", tag), 64'(bus.LO), 64'(e[W-1:0]));
    check($sformatf("%s.hi", tag), 64'(bus.HI), 64'(e[2*W-1:W]));
    last_lo = e[W-1:0];
    last_hi = e[2*W-1:W];
  endtask

  task automatic run_div(input string tag, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] elo,
                         input logic [W-1:0] ehi);
    start_op(s, a, b);
    wait_done(tag, -1);
    // Directed cases also carry hand-computed constants.
    check($sformatf("%s.lo_const", tag), 64'(bus.LO), 64'(elo));
    check($sformatf("%s.hi_const", tag), 64'(bus.HI), 64'(ehi));
  endtask

  initial begin
    bit seen_done;
    int idle;
    logic [W-1:0] ra, rb;
    logic rs;

    bus.START = 1'b0;
    bus.SIGN  = 1'b0;
    bus.ABORT = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    RESET     = 1'b1;
    #12;
    check("rst.busy",  64'(bus.BUSY), 64'd0);
    check("rst.done",  64'(bus.DONE), 64'd0);
    check("rst.hi",    64'(bus.HI),   64'd0);
    check("rst.lo",    64'(bus.LO),   64'd0);
    check("rst.state", 64'(dbg_state), 64'd0);
    tick;
    RESET = 1'b0;
    tick;

    // directed arithmetic
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    tick;
    check("done_pulse", 64'(bus.DONE), 64'd0);
    check("hold_lo", 64'(bus.LO), 64'(last_lo));
    run_div("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("divu_ovf",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_div("div_by0",    1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
    run_div("divu_by0",   1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

    // stray START at cycle 10 is ignored
    start_op(1'b0, 32'd1000, 32'd3);
    wait_done("start_busy", 10);
    check("start_busy.lo_const", 64'(bus.LO), 64'd333);
    tick;
    check("start_busy.idle", 64'(bus.BUSY), 64'd0);

    // ABORT in cycle 20 of RUN
    start_op(1'b1, $urandom, $urandom);
    for (int i = 1; i < 20; i++) tick;
    bus.ABORT = 1'b1;
    tick;
    bus.ABORT = 1'b0;
    exp_q.delete();
    check("abort_run.busy", 64'(bus.BUSY), 64'd0);
    check("abort_run.done", 64'(bus.DONE), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.DONE) seen_done = 1'b1;
      tick;
    end
    check("abort_run.no_done", 64'(seen_done), 64'd0);
    check("abort_run.hi", 64'(bus.HI), 64'(last_hi));
    check("abort_run.lo", 64'(bus.LO), 64'(last_lo));

    // ABORT in FIX (cycle 33)
    start_op(1'b0, 32'd77, 32'd5);
    for (int i = 1; i < 33; i++) tick;
    check("abort_fix.state", 64'(dbg_state), 64'd2);
    bus.ABORT = 1'b1;
    tick;
    bus.ABORT = 1'b0;
    exp_q.delete();
    check("abort_fix.done", 64'(bus.DONE), 64'd0);
    check("abort_fix.lo", 64'(bus.LO), 64'(last_lo));

    // ABORT together with START in IDLE drops the start
    bus.ABORT = 1'b1;
    bus.START = 1'b1;
    tick;
    bus.ABORT = 1'b0;
    bus.START = 1'b0;
    check("abort_start.busy", 64'(bus.BUSY), 64'd0);

    // back-to-back: second START in the DONE cycle
    start_op(1'b0, 32'd50, 32'd6);
    wait_done("b2b_first", -1);
    start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done("b2b_second", -1);

    // asynchronous reset in the middle of RUN
    start_op(1'b0, 32'd999, 32'd10);
    for (int i = 1; i < 10; i++) tick;
    #3;
    RESET = 1'b1;
    #1;
    exp_q.delete();
    check("rst_mid.busy",  64'(bus.BUSY), 64'd0);
    check("rst_mid.done",  64'(bus.DONE), 64'd0);
    check("rst_mid.hi",    64'(bus.HI),   64'd0);
    check("rst_mid.lo",    64'(bus.LO),   64'd0);
    check("rst_mid.state", 64'(dbg_state), 64'd0);
    tick;
    RESET = 1'b0;
    tick;
    run_div("after_rst", 1'b0, 32'd999, 32'd10, 32'd99, 32'd9);

    // randomized operations against the model
    for (int n = 0; n < 30; n++) begin
      rs = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      start_op(rs, ra, rb);
      wait_done($sformatf("rand%0d", n), -1);
      idle = $urandom_range(0, 2);
      if (idle > 0) begin
        tick;
        check($sformatf("rand%0d.pulse", n), 64'(bus.DONE), 64'd0);
        check($sformatf("rand%0d.hold", n), 64'({bus.HI, bus.LO}), 64'({last_hi, last_lo}));
        for (int i = 1; i < idle; i++) tick;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
